mux_sel_arbiter: RTL and testbench
==================================

MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, giving the maximum cycles one owner keeps the grant (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, active-low asynchronous reset.
REQ-004 The block SHALL have port req, input, 16, one request bit per 32-bit mux input (bit i requests input i).
REQ-005 The block SHALL have port done, input, 1, current owner releases the mux this cycle.
REQ-006 The block SHALL have port sel, output, 4, select code driven to the 16:1 32-bit mux.
REQ-007 The block SHALL have port grant, output, 16, one-hot grant, all-zero when no owner.
REQ-008 The block SHALL have port valid, output, 1, high exactly when grant is non-zero.
REQ-009 The block SHALL have port timeout, output, 1, one-cycle pulse when a grant is force-released by MAX_HOLD.

Function
REQ-010 The block SHALL implement states IDLE, OWN and GAP.
REQ-011 The block SHALL, in IDLE with req==0, stay in IDLE with grant=0, valid=0 and sel unchanged.
REQ-012 The block SHALL, in IDLE with req!=0, pick a winner round-robin and enter OWN next cycle, with grant, valid and sel registered (1-cycle request-to-grant latency).
REQ-013 The round-robin search SHALL start at index (last_owner+1) mod 16, ascend, and wrap 15->0; the first set req bit wins.
REQ-014 last_owner SHALL update to the winner on every grant.
REQ-015 The block SHALL, in OWN, hold grant and sel stable and count owned cycles in hold_cnt, starting at 0 on the first OWN cycle.
REQ-016 The block SHALL leave OWN for GAP when done=1, when req[owner]=0, or when hold_cnt==MAX_HOLD-1.
REQ-017 timeout SHALL pulse for the cycle GAP is entered, and only when the exit is forced by hold_cnt; done or req-drop in that same cycle SHALL take precedence and suppress timeout.
REQ-018 The block SHALL, in GAP, drive grant=0 and valid=0, keep sel at the last owner, and return to IDLE unconditionally after one cycle (bus turnaround).
REQ-019 done asserted outside OWN SHALL be ignored.
REQ-020 Changes to req while in OWN SHALL not affect grant except through REQ-016.
REQ-021 sel SHALL always equal the binary index of the set grant bit while valid=1.
REQ-022 Minimum spacing between two grants SHALL be 2 dead cycles (GAP, IDLE); a sole continuous requester is re-granted after that gap.

Reset
REQ-023 On reset low the block SHALL immediately force state=IDLE, grant=0, valid=0, timeout=0, sel=0, hold_cnt=0 and last_owner=15, so input 0 has top priority after reset.
REQ-024 Reset asserted mid-OWN SHALL drop the grant asynchronously, and no timeout pulse SHALL be produced.
REQ-025 After reset deassertion the first arbitration SHALL occur on the first rising edge with req!=0.

Structure
REQ-026 State enum, N_REQ=16 and SEL_W=4 SHALL live in shared package mips_arb_pkg.
REQ-027 The combinational winner search SHALL be sub-module rr_priority_pick (inputs req[15:0], start[3:0]; outputs found, idx[3:0]).
REQ-028 All outputs SHALL be driven from registers, with no combinational path from req or done.

Verification
REQ-029 Reset then req=16'h0001 held -> grant=16'h0001, sel=0, valid=1 one cycle after first edge; force-release after 8 OWN cycles with timeout=1; re-granted after 2 dead cycles.
REQ-030 req=16'h8001 held, done pulsed each grant -> grants alternate sel=0, 15, 0, 15.
REQ-031 Owner sel=3 with done=1 and hold_cnt=7 in the same cycle -> enters GAP, timeout=0.
REQ-032 Owner sel=5, req[5] drops while req[9]=1 -> GAP, IDLE, then grant=16'h0200, sel=9.
REQ-033 reset low during OWN at sel=12 -> grant=0, valid=0, sel=0 asynchronously; next grant with req=16'hFFFF -> sel=0.
REQ-034 Random req/done for 10k cycles -> grant always one-hot or zero, valid equals |grant, and no requester starved beyond 15 grants.

Source files
------------

// File: rtl/mips_arb_pkg.sv
// Shared types and sizes for the 16:1 mux select arbiter.
package mips_arb_pkg;

  localparam int N_REQ = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  // Decode a select code into its one-hot grant vector.
  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] one;
    one = {{(N_REQ-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin search: first set req bit at or after start, wrapping.
module rr_priority_pick
  import mips_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest set bit is written last.
  always_comb begin
    found = 1'b0;
    idx   = start;
    cand  = start;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = start + SEL_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin owner arbiter for a 16:1 32-bit mux with hold limit and turnaround gap.
module mux_sel_arbiter
  import mips_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] grant,
  output logic             valid,
  output logic             timeout
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  arb_state_e       state, state_nx;
  logic [3:0]       hold_cnt, hold_nx;
  logic [SEL_W-1:0] last_owner, last_nx;
  logic [SEL_W-1:0] sel_nx;
  logic [N_REQ-1:0] grant_nx;
  logic             valid_nx, timeout_nx;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;

  // Search starts just past the previous owner so every requester gets a turn.
  rr_priority_pick u_pick (
    .req   (req),
    .start (last_owner + SEL_W'(1)),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_nx   = state;
    hold_nx    = hold_cnt;
    last_nx    = last_owner;
    sel_nx     = sel;
    grant_nx   = grant;
    valid_nx   = valid;
    timeout_nx = 1'b0;
    unique case (state)
      IDLE: begin
        grant_nx = '0;
        valid_nx = 1'b0;
        if (pick_found) begin
          state_nx = OWN;
          grant_nx = onehot(pick_idx);
          valid_nx = 1'b1;
          sel_nx   = pick_idx;
          last_nx  = pick_idx;
          hold_nx  = 4'd0;
        end
      end
      OWN: begin
        // sel holds the owner index; a voluntary release beats the hold limit.
        if (done || !req[sel]) begin
          state_nx = GAP;
          grant_nx = '0;
          valid_nx = 1'b0;
          hold_nx  = 4'd0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nx   = GAP;
          grant_nx   = '0;
          valid_nx   = 1'b0;
          hold_nx    = 4'd0;
          timeout_nx = 1'b1;
        end else begin
          hold_nx = hold_cnt + 4'd1;
        end
      end
      GAP: begin
        // One turnaround cycle; sel keeps pointing at the last owner.
        state_nx = IDLE;
        grant_nx = '0;
        valid_nx = 1'b0;
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
        valid_nx = 1'b0;
        hold_nx  = 4'd0;
      end
    endcase
  end

  // State and output registers; reset clears the grant immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      hold_cnt   <= 4'd0;
      last_owner <= SEL_W'(N_REQ - 1);
      sel        <= '0;
      grant      <= '0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nx;
      hold_cnt   <= hold_nx;
      last_owner <= last_nx;
      sel        <= sel_nx;
      grant      <= grant_nx;
      valid      <= valid_nx;
      timeout    <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter against an owner/turn-based reference model.
module tb_mux_sel_arbiter;

  localparam int MAX_HOLD = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] req = '0;
  logic        done = 1'b0;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        valid;
  logic        timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the mux, for how many cycles, and whether a turnaround is pending.
  int   m_owner;
  int   m_held;
  int   m_last;
  int   m_sel;
  bit   m_gap;
  bit   m_to;

  mux_sel_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .grant   (grant),
    .valid   (valid),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] exp_vec();
    logic [15:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return {g, 4'(m_sel), (m_owner >= 0), m_to};
  endfunction

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_last = 15; m_sel = 0; m_gap = 0; m_to = 0;
  endtask

  task automatic model_update(input logic [15:0] r, input logic d);
    bit hit;
    m_to = 0;
    if (m_owner >= 0) begin
      if (d || !r[m_owner]) begin
        m_owner = -1; m_gap = 1;
      end else if (m_held == MAX_HOLD) begin
        m_owner = -1; m_gap = 1; m_to = 1;
      end else begin
        m_held++;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (r != 0) begin
      hit = 0;
      for (int k = 1; k <= 16; k++) begin
        if (!hit && r[(m_last + k) % 16]) begin
          hit = 1;
          m_owner = (m_last + k) % 16;
        end
      end
      m_last = m_owner; m_sel = m_owner; m_held = 1;
    end
  endtask

  // Apply inputs, clock one edge, advance the model, settle 1 time unit past the edge.
  task automatic tick(input logic [15:0] r, input logic d);
    req = r; done = d;
    @(posedge clk);
    model_update(r, d);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; req = '0; done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    n_checks++;
    if ({grant, sel, valid, timeout} !== 22'h0) begin
      n_errors++; $display("FAIL reset_async: got %h expected %h", {grant, sel, valid, timeout}, 22'h0);
    end
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(16'h0000, 1'b1);
      n_checks++;
      if ({grant, sel, valid, timeout} !== exp_vec()) begin
        n_errors++; $display("FAIL idle_noreq: got %h expected %h", {grant, sel, valid, timeout}, exp_vec());
      end
    end
    tick(16'h0004, 1'b0);
    n_checks++;
    if (grant !== 16'h0004 || sel !== 4'd2 || valid !== 1'b1) begin
      n_errors++; $display("FAIL first_arb: got grant=%h sel=%0d expected grant=0004 sel=2", grant, sel);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      tick(16'h0001, 1'b0);
      n_checks++;
      if ({grant, sel, valid, timeout} !== exp_vec()) begin
        n_errors++; $display("FAIL timeout_seq cyc%0d: got %h expected %h", i, {grant, sel, valid, timeout}, exp_vec());
      end
      if (i == 1 || i == 8 || i == 11) begin
        n_checks++;
        if (grant !== 16'h0001 || sel !== 4'd0 || valid !== 1'b1 || timeout !== 1'b0) begin
          n_errors++; $display("FAIL timeout_owned cyc%0d: got grant=%h valid=%b expected 0001/1", i, grant, valid);
        end
      end
      if (i == 9) begin
        n_checks++;
        if (timeout !== 1'b1 || valid !== 1'b0 || grant !== 16'h0) begin
          n_errors++; $display("FAIL timeout_pulse: got timeout=%b valid=%b expected 1/0", timeout, valid);
        end
      end
      if (i == 10) begin
        n_checks++;
        if (timeout !== 1'b0 || valid !== 1'b0 || sel !== 4'd0) begin
          n_errors++; $display("FAIL timeout_gap2: got timeout=%b valid=%b sel=%0d expected 0/0/0", timeout, valid, sel);
        end
      end
    end
  endtask

  task automatic test_alternate();
    int sels[$];
    int want[4];
    bit prev_v;
    want = '{0, 15, 0, 15};
    do_reset();
    prev_v = 1'b0;
    for (int i = 0; i < 40 && sels.size() < 4; i++) begin
      tick(16'h8001, valid);
      if (valid && !prev_v) sels.push_back(int'(sel));
      prev_v = valid;
    end
    n_checks++;
    if (sels.size() != 4) begin
      n_errors++; $display("FAIL alternate_count: got %0d grants expected 4", sels.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (sels[k] != want[k]) begin
          n_errors++; $display("FAIL alternate_sel%0d: got %0d expected %0d", k, sels[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_done_at_limit();
    do_reset();
    for (int i = 1; i <= 8; i++) tick(16'h0008, 1'b0);
    n_checks++;
    if (sel !== 4'd3 || valid !== 1'b1) begin
      n_errors++; $display("FAIL done_limit_own: got sel=%0d valid=%b expected 3/1", sel, valid);
    end
    tick(16'h0008, 1'b1);
    n_checks++;
    if (timeout !== 1'b0 || valid !== 1'b0 || grant !== 16'h0 || sel !== 4'd3) begin
      n_errors++; $display("FAIL done_limit_gap: got timeout=%b valid=%b sel=%0d expected 0/0/3", timeout, valid, sel);
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    tick(16'h0020, 1'b0);
    tick(16'h0020, 1'b0);
    n_checks++;
    if (grant !== 16'h0020 || sel !== 4'd5) begin
      n_errors++; $display("FAIL drop_own: got grant=%h sel=%0d expected 0020/5", grant, sel);
    end
    for (int i = 1; i <= 3; i++) begin
      tick(16'h0200, 1'b0);
      n_checks++;
      if ({grant, sel, valid, timeout} !== exp_vec()) begin
        n_errors++; $display("FAIL drop_seq cyc%0d: got %h expected %h", i, {grant, sel, valid, timeout}, exp_vec());
      end
    end
    n_checks++;
    if (grant !== 16'h0200 || sel !== 4'd9 || valid !== 1'b1) begin
      n_errors++; $display("FAIL drop_regrant: got grant=%h sel=%0d expected 0200/9", grant, sel);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(16'h1000, 1'b0);
    tick(16'h1000, 1'b0);
    n_checks++;
    if (sel !== 4'd12 || valid !== 1'b1) begin
      n_errors++; $display("FAIL areset_own: got sel=%0d valid=%b expected 12/1", sel, valid);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (grant !== 16'h0 || valid !== 1'b0 || sel !== 4'd0 || timeout !== 1'b0) begin
      n_errors++; $display("FAIL areset_drop: got grant=%h valid=%b sel=%0d expected 0/0/0", grant, valid, sel);
    end
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b1;
    tick(16'hFFFF, 1'b0);
    n_checks++;
    if (grant !== 16'h0001 || sel !== 4'd0 || timeout !== 1'b0) begin
      n_errors++; $display("FAIL areset_regrant: got grant=%h sel=%0d expected 0001/0", grant, sel);
    end
  endtask

  task automatic test_random();
    int waitc[16];
    logic [15:0] r;
    logic d;
    bit prev_v;
    do_reset();
    foreach (waitc[i]) waitc[i] = 0;
    r = 16'hA5C3;
    prev_v = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 5) == 0) r = 16'($urandom) & 16'($urandom | $urandom);
      d = ($urandom_range(0, 9) == 0);
      tick(r, d);
      n_checks++;
      if ({grant, sel, valid, timeout} !== exp_vec()) begin
        n_errors++; $display("FAIL rand_model cyc%0d: got %h expected %h", c, {grant, sel, valid, timeout}, exp_vec());
      end
      n_checks++;
      if (!$onehot0(grant) || valid !== (|grant)) begin
        n_errors++; $display("FAIL rand_onehot cyc%0d: got grant=%h valid=%b", c, grant, valid);
      end
      if (valid && !prev_v) begin
        for (int i = 0; i < 16; i++) begin
          if (i == int'(sel)) waitc[i] = 0;
          else if (r[i]) waitc[i]++;
          else waitc[i] = 0;
        end
        n_checks++;
        for (int i = 0; i < 16; i++) begin
          if (waitc[i] > 15) begin
            n_errors++; $display("FAIL rand_starve req%0d: got %0d grants waited expected <=15", i, waitc[i]);
          end
        end
      end
      prev_v = valid;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_timeout();
    test_alternate();
    test_done_at_limit();
    test_req_drop();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
